mycpu_id_stage: RTL and testbench

// - Pipelined MIPS-subset decode stage: decodes one instruction, reads the

---
 rtl/mycpu_id_stage.sv | 215 +++++++++++++++++++++
 tb/tb_mycpu_id_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mycpu_id_stage.sv
// MIPS-subset decode stage: decode, register-file read, operand forwarding, branch
// resolution, and the ID/EX register. Define MYCPU_ID_FWD_EN to enable EX/MEM forwarding.
module mycpu_id_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREG    = 32,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               wb_wen,
    input  logic [4:0]         wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               ex_wen,
    input  logic [4:0]         ex_addr,
    input  logic [XLEN-1:0]    ex_data,
    input  logic               ex_is_load,
    input  logic               mem_wen,
    input  logic [4:0]         mem_addr,
    input  logic [XLEN-1:0]    mem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_a,
    output logic [XLEN-1:0]    out_b,
    output logic [XLEN-1:0]    out_st_data,
    output logic [4:0]         out_dest,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic               out_reg_wen,
    output logic               out_mem_to_reg,
    output logic               out_mem_wen,
    output logic               br_taken,
    output logic [XLEN-1:0]    br_target
);

    localparam int unsigned NSLOT = 32;

    typedef enum logic [1:0] {A_RS, A_SHAMT, A_ZERO}    a_sel_e;
    typedef enum logic [1:0] {B_RT, B_SEXT, B_LUI}      b_sel_e;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ} br_kind_e;

    logic [XLEN-1:0] rf_q [NSLOT];

    logic [5:0]  op;
    logic [4:0]  rs_a, rt_a, rd_a, shamt;
    logic [5:0]  func;
    logic [15:0] imm;
    assign op    = in_inst[31:26];
    assign rs_a  = in_inst[25:21];
    assign rt_a  = in_inst[20:16];
    assign rd_a  = in_inst[15:11];
    assign shamt = in_inst[10:6];
    assign func  = in_inst[5:0];
    assign imm   = in_inst[15:0];

    logic       use_rs, use_rt, dest_rt, dec_reg_wen, dec_mem_to_reg, dec_mem_wen;
    logic [3:0] dec_aluop;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    br_kind_e   br_kind;

    // Instruction decode; anything unrecognised stays a NOP with no sources.
    always_comb begin
        use_rs         = 1'b0;
        use_rt         = 1'b0;
        dest_rt        = 1'b0;
        dec_reg_wen    = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_wen    = 1'b0;
        dec_aluop      = 4'd0;
        a_sel          = A_RS;
        b_sel          = B_RT;
        br_kind        = BR_NONE;
        case (op)
            6'h00: begin
                dec_reg_wen = 1'b1;
                use_rs      = 1'b1;
                use_rt      = 1'b1;
                case (func)
                    6'h00: begin dec_aluop = 4'h8; a_sel = A_SHAMT; use_rs = 1'b0; end
                    6'h02: begin dec_aluop = 4'hA; a_sel = A_SHAMT; use_rs = 1'b0; end
                    6'h03: begin dec_aluop = 4'hB; a_sel = A_SHAMT; use_rs = 1'b0; end
                    6'h04: dec_aluop = 4'h8;
                    6'h06: dec_aluop = 4'hA;
                    6'h07: dec_aluop = 4'hB;
                    6'h21: dec_aluop = 4'h0;
                    6'h23: dec_aluop = 4'h1;
                    6'h24: dec_aluop = 4'h4;
                    6'h25: dec_aluop = 4'h5;
                    6'h26: dec_aluop = 4'h6;
                    6'h27: dec_aluop = 4'h7;
                    6'h2A: dec_aluop = 4'h2;
                    6'h2B: dec_aluop = 4'h3;
                    default: begin dec_reg_wen = 1'b0; use_rs = 1'b0; use_rt = 1'b0; end
                endcase
            end
            6'h09: begin use_rs = 1'b1; b_sel = B_SEXT; dest_rt = 1'b1; dec_reg_wen = 1'b1; end
            6'h23: begin
                use_rs = 1'b1; b_sel = B_SEXT; dest_rt = 1'b1;
                dec_reg_wen = 1'b1; dec_mem_to_reg = 1'b1;
            end
            6'h2B: begin use_rs = 1'b1; use_rt = 1'b1; b_sel = B_SEXT; dec_mem_wen = 1'b1; end
            6'h0F: begin a_sel = A_ZERO; b_sel = B_LUI; dest_rt = 1'b1; dec_reg_wen = 1'b1; dec_aluop = 4'h5; end
            6'h04: begin use_rs = 1'b1; use_rt = 1'b1; br_kind = BR_EQ;  end
            6'h05: begin use_rs = 1'b1; use_rt = 1'b1; br_kind = BR_NE;  end
            6'h06: begin use_rs = 1'b1; br_kind = BR_LEZ; end
            6'h07: begin use_rs = 1'b1; br_kind = BR_GTZ; end
            default: ;
        endcase
    end

    // Source value with bypass priority EX > MEM > WB > regfile; r0 and r>=NREG read 0.
    function automatic logic [XLEN-1:0] src_val(input logic [4:0] addr);
        logic [XLEN-1:0] v;
        v = rf_q[addr];
        if (wb_wen && wb_addr == addr) v = wb_data;
`ifdef MYCPU_ID_FWD_EN
        if (mem_wen && mem_addr == addr) v = mem_data;
        if (ex_wen && ex_addr == addr) v = ex_data;
`endif
        if (addr == 5'd0 || {1'b0, addr} >= 6'(NREG)) v = '0;
        return v;
    endfunction

    logic [XLEN-1:0] rs_v, rt_v, imm_sx, a_c, b_c, target_c;
    logic            taken_c, stall_c, accept_c;

    always_comb begin
        rs_v     = src_val(rs_a);
        rt_v     = src_val(rt_a);
        imm_sx   = {{(XLEN-16){imm[15]}}, imm};
        target_c = in_pc + XLEN'(4) + {imm_sx[XLEN-3:0], 2'b00};
        a_c      = rs_v;
        b_c      = rt_v;
        taken_c  = 1'b0;
        case (a_sel)
            A_SHAMT: a_c = {{(XLEN-5){1'b0}}, shamt};
            A_ZERO:  a_c = '0;
            default: a_c = rs_v;
        endcase
        case (b_sel)
            B_SEXT:  b_c = imm_sx;
            B_LUI:   b_c = {{(XLEN-32){1'b0}}, imm, 16'h0000};
            default: b_c = rt_v;
        endcase
        case (br_kind)
            BR_EQ:   taken_c = (rs_v == rt_v);
            BR_NE:   taken_c = (rs_v != rt_v);
            BR_LEZ:  taken_c = rs_v[XLEN-1] || (rs_v == '0);
            BR_GTZ:  taken_c = !rs_v[XLEN-1] && (rs_v != '0);
            default: taken_c = 1'b0;
        endcase
    end

    // Hazard interlock: load-use only with forwarding, any pending producer without.
`ifdef MYCPU_ID_FWD_EN
    assign stall_c = ex_wen && ex_is_load && (ex_addr != 5'd0) &&
                     ((use_rs && rs_a == ex_addr) || (use_rt && rt_a == ex_addr));
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_data, mem_data, ex_is_load};
    assign stall_c = (ex_wen && (ex_addr != 5'd0) &&
                      ((use_rs && rs_a == ex_addr) || (use_rt && rt_a == ex_addr))) ||
                     (mem_wen && (mem_addr != 5'd0) &&
                      ((use_rs && rs_a == mem_addr) || (use_rt && rt_a == mem_addr)));
`endif

    assign in_ready = (!out_valid || out_ready) && !stall_c;
    assign accept_c = in_valid && in_ready;

    // Register file: write port runs every cycle, r0 and r>=NREG never stored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NSLOT; i++) rf_q[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NSLOT; i++)
                if (i < NREG && wb_wen && wb_addr == 5'(i)) rf_q[i] <= wb_data;
        end
    end

    // ID/EX register: load on accept, drop valid after a handshake with nothing new.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_a          <= '0;
            out_b          <= '0;
            out_st_data    <= '0;
            out_dest       <= '0;
            out_aluop      <= '0;
            out_reg_wen    <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_mem_wen    <= 1'b0;
            br_taken       <= 1'b0;
            br_target      <= '0;
        end else if (accept_c) begin
            out_valid      <= 1'b1;
            out_a          <= a_c;
            out_b          <= b_c;
            out_st_data    <= rt_v;
            out_dest       <= dest_rt ? rt_a : rd_a;
            out_aluop      <= ALUOP_W'(dec_aluop);
            out_reg_wen    <= dec_reg_wen;
            out_mem_to_reg <= dec_mem_to_reg;
            out_mem_wen    <= dec_mem_wen;
            br_taken       <= taken_c;
            br_target      <= target_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            br_taken  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mycpu_id_stage.sv
// Directed bench for mycpu_id_stage: decode, bypass, interlock, branch and backpressure.
module tb_mycpu_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_inst, in_pc;
    logic        wb_wen, ex_wen, ex_is_load, mem_wen;
    logic [4:0]  wb_addr, ex_addr, mem_addr;
    logic [31:0] wb_data, ex_data, mem_data;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b, out_st_data, br_target;
    logic [4:0]  out_dest;
    logic [3:0]  out_aluop;
    logic        out_reg_wen, out_mem_to_reg, out_mem_wen, br_taken;

    int nvec = 0;
    int nerr = 0;

    mycpu_id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_wen(ex_wen), .ex_addr(ex_addr), .ex_data(ex_data), .ex_is_load(ex_is_load),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_st_data(out_st_data), .out_dest(out_dest),
        .out_aluop(out_aluop), .out_reg_wen(out_reg_wen), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_wen(out_mem_wen), .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        wb_wen = 1'b0; wb_addr = '0; wb_data = '0;
        ex_wen = 1'b0; ex_addr = '0; ex_data = '0; ex_is_load = 1'b0;
        mem_wen = 1'b0; mem_addr = '0; mem_data = '0;
        #3;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
        nvec++; if (br_taken !== 1'b0) begin nerr++; $display("FAIL reset br_taken got %b exp 0", br_taken); end
        nvec++; if (out_a !== 32'h0 || out_dest !== 5'd0) begin nerr++; $display("FAIL reset out_a/dest got %h/%0d exp 0/0", out_a, out_dest); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_wb_through();
        wb_wen = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
        offer(enc_r(5'd3, 5'd0, 5'd4, 5'd0, 6'h21), 32'h40);
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL wbthru in_ready got %b exp 1", in_ready); end
        tick();
        nvec++; if (out_valid !== 1'b1 || out_a !== 32'h1234 || out_b !== 32'h0) begin nerr++; $display("FAIL wbthru v/a/b got %b/%h/%h exp 1/00001234/0", out_valid, out_a, out_b); end
        nvec++; if (out_dest !== 5'd4 || out_aluop !== 4'd0 || out_reg_wen !== 1'b1) begin nerr++; $display("FAIL wbthru dest/op/wen got %0d/%0d/%b exp 4/0/1", out_dest, out_aluop, out_reg_wen); end
        wb_wen = 1'b0;
        offer(enc_r(5'd3, 5'd3, 5'd5, 5'd0, 6'h23), 32'h44);
        tick();
        nvec++; if (out_a !== 32'h1234 || out_b !== 32'h1234 || out_aluop !== 4'd1) begin nerr++; $display("FAIL rfread a/b/op got %h/%h/%0d exp 1234/1234/1", out_a, out_b, out_aluop); end
        in_valid = 1'b0;
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL drop out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_forward();
        ex_wen = 1'b1; ex_addr = 5'd2; ex_data = 32'hA;
        mem_wen = 1'b1; mem_addr = 5'd2; mem_data = 32'hB;
        offer(enc_r(5'd2, 5'd2, 5'd1, 5'd0, 6'h21), 32'h50);
        #1;
`ifdef MYCPU_ID_FWD_EN
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL fwd in_ready got %b exp 1", in_ready); end
        tick();
        nvec++; if (out_a !== 32'hA || out_b !== 32'hA) begin nerr++; $display("FAIL fwd_ex a/b got %h/%h exp a/a", out_a, out_b); end
        ex_wen = 1'b0;
        offer(enc_r(5'd2, 5'd0, 5'd1, 5'd0, 6'h25), 32'h54);
        tick();
        nvec++; if (out_a !== 32'hB || out_aluop !== 4'd5) begin nerr++; $display("FAIL fwd_mem a/op got %h/%0d exp b/5", out_a, out_aluop); end
        mem_wen = 1'b0;
`else
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL nofwd stall in_ready got %b exp 0", in_ready); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL nofwd stall out_valid got %b exp 0", out_valid); end
        ex_wen = 1'b0;
        #1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL nofwd mem stall in_ready got %b exp 0", in_ready); end
        tick();
        mem_wen = 1'b0; wb_wen = 1'b1; wb_addr = 5'd2; wb_data = 32'h77;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL nofwd release in_ready got %b exp 1", in_ready); end
        tick();
        nvec++; if (out_valid !== 1'b1 || out_a !== 32'h77 || out_b !== 32'h77) begin nerr++; $display("FAIL nofwd a/b got %b/%h/%h exp 1/77/77", out_valid, out_a, out_b); end
        wb_wen = 1'b0;
`endif
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_addr = 5'd8; ex_data = 32'hDEAD;
        offer(enc_r(5'd8, 5'd0, 5'd9, 5'd0, 6'h21), 32'h60);
        #1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL loaduse in_ready got %b exp 0", in_ready); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL loaduse out_valid got %b exp 0", out_valid); end
        ex_wen = 1'b0; ex_is_load = 1'b0;
        wb_wen = 1'b1; wb_addr = 5'd8; wb_data = 32'h55;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL loaduse release in_ready got %b exp 1", in_ready); end
        tick();
        nvec++; if (out_valid !== 1'b1 || out_a !== 32'h55 || out_dest !== 5'd9) begin nerr++; $display("FAIL loaduse v/a/dest got %b/%h/%0d exp 1/55/9", out_valid, out_a, out_dest); end
        wb_wen = 1'b0;
        ex_wen = 1'b1; ex_is_load = 1'b1; ex_addr = 5'd8;
        offer(enc_r(5'd8, 5'd3, 5'd1, 5'd3, 6'h00), 32'h64);
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL sll_nostall in_ready got %b exp 1", in_ready); end
        tick();
        nvec++; if (out_a !== 32'h3 || out_b !== 32'h1234 || out_aluop !== 4'h8) begin nerr++; $display("FAIL sll a/b/op got %h/%h/%0d exp 3/1234/8", out_a, out_b, out_aluop); end
        ex_wen = 1'b0; ex_is_load = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_branch();
        offer(enc_i(6'h04, 5'd0, 5'd0, 16'h0003), 32'h100);
        tick();
        nvec++; if (out_valid !== 1'b1 || br_taken !== 1'b1 || br_target !== 32'h110) begin nerr++; $display("FAIL beq v/taken/target got %b/%b/%h exp 1/1/110", out_valid, br_taken, br_target); end
        nvec++; if (out_reg_wen !== 1'b0 || out_mem_wen !== 1'b0) begin nerr++; $display("FAIL beq wen/mwen got %b/%b exp 0/0", out_reg_wen, out_mem_wen); end
        offer(enc_i(6'h07, 5'd0, 5'd0, 16'h0000), 32'h200);
        tick();
        nvec++; if (out_valid !== 1'b1 || br_taken !== 1'b0) begin nerr++; $display("FAIL bgtz_zero v/taken got %b/%b exp 1/0", out_valid, br_taken); end
        wb_wen = 1'b1; wb_addr = 5'd6; wb_data = 32'hFFFF_FFFF;
        offer(enc_i(6'h06, 5'd6, 5'd0, 16'hFFFF), 32'h20);
        tick();
        nvec++; if (br_taken !== 1'b1 || br_target !== 32'h20) begin nerr++; $display("FAIL blez_neg taken/target got %b/%h exp 1/20", br_taken, br_target); end
        wb_wen = 1'b0;
        offer(enc_i(6'h07, 5'd6, 5'd0, 16'h0000), 32'h30);
        tick();
        nvec++; if (br_taken !== 1'b0 || br_target !== 32'h34) begin nerr++; $display("FAIL bgtz_neg taken/target got %b/%h exp 0/34", br_taken, br_target); end
        offer(enc_i(6'h05, 5'd3, 5'd0, 16'h0000), 32'hFFFF_FFFC);
        tick();
        nvec++; if (br_taken !== 1'b1 || br_target !== 32'h0) begin nerr++; $display("FAIL bne_wrap taken/target got %b/%h exp 1/0", br_taken, br_target); end
        in_valid = 1'b0;
        tick();
        nvec++; if (out_valid !== 1'b0 || br_taken !== 1'b0) begin nerr++; $display("FAIL br_drop v/taken got %b/%b exp 0/0", out_valid, br_taken); end
    endtask

    task automatic test_back_to_back();
        offer(enc_i(6'h2B, 5'd0, 5'd3, 16'hFFFC), 32'h70);
        tick();
        nvec++; if (out_a !== 32'h0 || out_b !== 32'hFFFF_FFFC || out_st_data !== 32'h1234) begin nerr++; $display("FAIL sw a/b/st got %h/%h/%h exp 0/fffffffc/1234", out_a, out_b, out_st_data); end
        nvec++; if (out_mem_wen !== 1'b1 || out_reg_wen !== 1'b0) begin nerr++; $display("FAIL sw mwen/wen got %b/%b exp 1/0", out_mem_wen, out_reg_wen); end
        offer(enc_i(6'h23, 5'd3, 5'd7, 16'h0010), 32'h74);
        tick();
        nvec++; if (out_a !== 32'h1234 || out_b !== 32'h10 || out_dest !== 5'd7) begin nerr++; $display("FAIL lw a/b/dest got %h/%h/%0d exp 1234/10/7", out_a, out_b, out_dest); end
        nvec++; if (out_mem_to_reg !== 1'b1 || out_reg_wen !== 1'b1 || out_mem_wen !== 1'b0) begin nerr++; $display("FAIL lw m2r/wen/mwen got %b/%b/%b exp 1/1/0", out_mem_to_reg, out_reg_wen, out_mem_wen); end
        offer(enc_i(6'h0F, 5'd0, 5'd9, 16'hABCD), 32'h78);
        tick();
        nvec++; if (out_a !== 32'h0 || out_b !== 32'hABCD_0000 || out_aluop !== 4'd5 || out_dest !== 5'd9) begin nerr++; $display("FAIL lui a/b/op/dest got %h/%h/%0d/%0d exp 0/abcd0000/5/9", out_a, out_b, out_aluop, out_dest); end
        offer(enc_i(6'h3F, 5'd1, 5'd2, 16'h0003), 32'h7C);
        tick();
        nvec++; if (out_valid !== 1'b1 || out_reg_wen !== 1'b0 || out_mem_wen !== 1'b0 || out_mem_to_reg !== 1'b0 || out_aluop !== 4'd0 || br_taken !== 1'b0) begin nerr++; $display("FAIL nop v/wen/mwen/m2r/op/br got %b/%b/%b/%b/%0d/%b exp 1/0/0/0/0/0", out_valid, out_reg_wen, out_mem_wen, out_mem_to_reg, out_aluop, br_taken); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        offer(enc_r(5'd3, 5'd3, 5'd4, 5'd0, 6'h21), 32'h80);
        tick();
        nvec++; if (out_valid !== 1'b1 || out_a !== 32'h1234) begin nerr++; $display("FAIL bp_first v/a got %b/%h exp 1/1234", out_valid, out_a); end
        out_ready = 1'b0;
        offer(enc_r(5'd0, 5'd0, 5'd5, 5'd0, 6'h26), 32'h84);
        #1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp in_ready got %b exp 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            nvec++; if (out_valid !== 1'b1 || out_a !== 32'h1234 || out_dest !== 5'd4 || out_aluop !== 4'd0 || in_ready !== 1'b0) begin nerr++; $display("FAIL bp_hold[%0d] v/a/dest/op/rdy got %b/%h/%0d/%0d/%b exp 1/1234/4/0/0", k, out_valid, out_a, out_dest, out_aluop, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release in_ready got %b exp 1", in_ready); end
        tick();
        nvec++; if (out_dest !== 5'd5 || out_aluop !== 4'd6 || out_a !== 32'h0) begin nerr++; $display("FAIL bp_next dest/op/a got %0d/%0d/%h exp 5/6/0", out_dest, out_aluop, out_a); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        wb_wen = 1'b1; wb_addr = 5'd5; wb_data = 32'h99;
        offer(enc_i(6'h04, 5'd0, 5'd0, 16'h0003), 32'h100);
        tick();
        nvec++; if (br_taken !== 1'b1) begin nerr++; $display("FAIL rstmid pre br_taken got %b exp 1", br_taken); end
        wb_wen = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        nvec++; if (out_valid !== 1'b0 || br_taken !== 1'b0 || br_target !== 32'h0) begin nerr++; $display("FAIL rstmid v/taken/target got %b/%b/%h exp 0/0/0", out_valid, br_taken, br_target); end
        tick();
        rst = 1'b1; out_ready = 1'b1;
        offer(enc_r(5'd5, 5'd5, 5'd1, 5'd0, 6'h21), 32'h90);
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rstmid in_ready got %b exp 1", in_ready); end
        tick();
        nvec++; if (out_valid !== 1'b1 || out_a !== 32'h0 || out_b !== 32'h0) begin nerr++; $display("FAIL rstmid r5 v/a/b got %b/%h/%h exp 1/0/0", out_valid, out_a, out_b); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_wb_through();
        test_forward();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
